// File: rtl/bexkat2_intseq_if.sv
// bexkat2 integer sequencer request/response bundle.
// master drives the request side, slave returns status and result.
interface bexkat2_intseq_if #(
   parameter int WIDTH = 32
);
   logic             start_i;
   logic [3:0]       func_i;
   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] result_o;
   logic             dbz_o;
   logic             illegal_o;

   modport master (
      output start_i, func_i, a_i, b_i,
      input  busy_o, done_o, result_o, dbz_o, illegal_o
   );

   modport slave (
      input  start_i, func_i, a_i, b_i,
      output busy_o, done_o, result_o, dbz_o, illegal_o
   );
endinterface

// File: rtl/bexkat2_intseq.sv
// bexkat2 integer unit sequencer: one-cycle unary ops,
// bit-serial multiply and restoring divide.
module bexkat2_intseq #(
   parameter int WIDTH = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   bexkat2_intseq_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   localparam logic [3:0] F_MUL   = 4'd0;
   localparam logic [3:0] F_DIV   = 4'd1;
   localparam logic [3:0] F_MOD   = 4'd2;
   localparam logic [3:0] F_MULU  = 4'd3;
   localparam logic [3:0] F_DIVU  = 4'd4;
   localparam logic [3:0] F_MODU  = 4'd5;
   localparam logic [3:0] F_MULX  = 4'd6;
   localparam logic [3:0] F_MULUX = 4'd7;
   localparam logic [3:0] F_EXT   = 4'd8;
   localparam logic [3:0] F_EXTB  = 4'd9;
   localparam logic [3:0] F_COM   = 4'd10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [3:0]         func_q, func_d;
   logic               neg_q, neg_d;
   logic               sa_q, sa_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               dbz_q, dbz_d;
   logic               ill_q, ill_d;
   logic               done_q, done_d;

   logic               in_sgn, in_mul, in_div, in_quot, b_zero;
   logic [WIDTH-1:0]   mag_a, mag_b, ext16, ext8;

   // Decode the incoming request and form operand magnitudes.
   always_comb begin
      in_sgn  = (bus.func_i == F_MUL) || (bus.func_i == F_DIV) ||
                (bus.func_i == F_MOD) || (bus.func_i == F_MULX);
      in_mul  = (bus.func_i == F_MUL) || (bus.func_i == F_MULU) ||
                (bus.func_i == F_MULX) || (bus.func_i == F_MULUX);
      in_div  = (bus.func_i == F_DIV) || (bus.func_i == F_MOD) ||
                (bus.func_i == F_DIVU) || (bus.func_i == F_MODU);
      in_quot = (bus.func_i == F_DIV) || (bus.func_i == F_DIVU);
      b_zero  = (bus.b_i == '0);
      mag_a   = (in_sgn && bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
      mag_b   = (in_sgn && bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;
      ext16        = {WIDTH{bus.a_i[15]}};
      ext16[15:0]  = bus.a_i[15:0];
      ext8         = {WIDTH{bus.a_i[7]}};
      ext8[7:0]    = bus.a_i[7:0];
   end

   logic               q_mul, q_hi, q_quot;
   logic [WIDTH:0]     sum, shf, diff;
   logic [2*WIDTH-1:0] step, fixp;
   logic [WIDTH-1:0]   quo, rem;

   // One shift-add or restore-subtract step, plus final sign fix-up.
   always_comb begin
      q_mul  = (func_q == F_MUL) || (func_q == F_MULU) ||
               (func_q == F_MULX) || (func_q == F_MULUX);
      q_hi   = (func_q == F_MULX) || (func_q == F_MULUX);
      q_quot = (func_q == F_DIV) || (func_q == F_DIVU);
      sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
             {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
      shf  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      diff = shf - {1'b0, opnd_q};
      if (q_mul)
         step = {sum, acc_q[WIDTH-1:1]};
      else if (!diff[WIDTH])
         step = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
         step = {shf[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      fixp = neg_q ? -acc_q : acc_q;
      quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

   // Sequencer next-state and result selection.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      func_d   = func_q;
      neg_d    = neg_q;
      sa_d     = sa_q;
      result_d = result_q;
      dbz_d    = dbz_q;
      ill_d    = ill_q;
      done_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start_i) begin
               func_d = bus.func_i;
               neg_d  = in_sgn & (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
               sa_d   = in_sgn & bus.a_i[WIDTH-1];
               unique case (1'b1)
                  (bus.func_i >= 4'd12): begin
                     result_d = '0;
                     ill_d    = 1'b1;
                     dbz_d    = 1'b0;
                     done_d   = 1'b1;
                  end
                  in_mul: begin
                     state_d = S_RUN;
                     cnt_d   = CW'(WIDTH - 1);
                     acc_d   = {{WIDTH{1'b0}}, mag_b};
                     opnd_d  = mag_a;
                  end
                  (in_div && b_zero): begin
                     result_d = in_quot ? '1 : bus.a_i;
                     dbz_d    = 1'b1;
                     ill_d    = 1'b0;
                     done_d   = 1'b1;
                  end
                  (in_div && !b_zero): begin
                     state_d = S_RUN;
                     cnt_d   = CW'(WIDTH - 1);
                     acc_d   = {{WIDTH{1'b0}}, mag_a};
                     opnd_d  = mag_b;
                  end
                  default: begin
                     dbz_d  = 1'b0;
                     ill_d  = 1'b0;
                     done_d = 1'b1;
                     case (bus.func_i)
                        F_EXT:   result_d = ext16;
                        F_EXTB:  result_d = ext8;
                        F_COM:   result_d = ~bus.a_i;
                        default: result_d = -bus.a_i;
                     endcase
                  end
               endcase
            end
         end
         S_RUN: begin
            acc_d = step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0)
               state_d = S_FIX;
         end
         S_FIX: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            dbz_d   = 1'b0;
            ill_d   = 1'b0;
            if (q_mul)
               result_d = q_hi ? fixp[2*WIDTH-1:WIDTH] : fixp[WIDTH-1:0];
            else
               result_d = q_quot ? quo : rem;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         func_q   <= '0;
         neg_q    <= 1'b0;
         sa_q     <= 1'b0;
         result_q <= '0;
         dbz_q    <= 1'b0;
         ill_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         func_q   <= func_d;
         neg_q    <= neg_d;
         sa_q     <= sa_d;
         result_q <= result_d;
         dbz_q    <= dbz_d;
         ill_q    <= ill_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy_o    = (state_q != S_IDLE);
   assign bus.done_o    = done_q;
   assign bus.result_o  = result_q;
   assign bus.dbz_o     = dbz_q;
   assign bus.illegal_o = ill_q;

endmodule

// File: tb/tb_bexkat2_intseq.sv
// Testbench for bexkat2_intseq: directed cases plus random
// operations against an arithmetic reference model.
module tb_bexkat2_intseq;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   bexkat2_intseq_if #(.WIDTH(32)) bus ();

   bexkat2_intseq #(.WIDTH(32)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain 64-bit arithmetic on the operation's definition.
   function automatic void model(input logic [3:0] f,
                                 input logic [31:0] a,
                                 input logic [31:0] b,
                                 output logic [31:0] r,
                                 output logic dz,
                                 output logic il,
                                 output int lat,
                                 output int bsy);
      longint sa, sb;
      longint unsigned ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      r = '0; dz = 1'b0; il = 1'b0; lat = 1; bsy = 0;
      case (f)
         4'd0, 4'd6: begin
            p = sa * sb;
            r = (f == 4'd0) ? p[31:0] : p[63:32];
            lat = 34; bsy = 33;
         end
         4'd3, 4'd7: begin
            p = ua * ub;
            r = (f == 4'd3) ? p[31:0] : p[63:32];
            lat = 34; bsy = 33;
         end
         4'd1, 4'd2, 4'd4, 4'd5: begin
            if (b == 32'd0) begin
               dz = 1'b1;
               r = (f == 4'd1 || f == 4'd4) ? 32'hFFFF_FFFF : a;
            end else begin
               lat = 34; bsy = 33;
               if (f == 4'd1) p = sa / sb;
               else if (f == 4'd2) p = sa % sb;
               else if (f == 4'd4) p = ua / ub;
               else p = ua % ub;
               r = p[31:0];
            end
         end
         4'd8:  begin p = sa << 48; p = $signed(p) >>> 48; r = p[31:0]; end
         4'd9:  begin p = sa << 56; p = $signed(p) >>> 56; r = p[31:0]; end
         4'd10: r = ~a;
         4'd11: r = 32'd0 - a;
         default: il = 1'b1;
      endcase
   endfunction

   // Issue one request and wait (bounded) for its completion.
   task automatic do_op(input logic [3:0] f, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] r,
                        output logic dz, output logic il,
                        output int lat, output int bsy);
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.func_i  = f;
      bus.a_i     = a;
      bus.b_i     = b;
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.func_i  = 4'($urandom);
      bus.a_i     = $urandom;
      bus.b_i     = $urandom;
      lat = 1; bsy = 0;
      while (!bus.done_o && lat < 100) begin
         if (bus.busy_o) bsy++;
         @(negedge clk);
         lat++;
      end
      r  = bus.result_o;
      dz = bus.dbz_o;
      il = bus.illegal_o;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start_i = 1'b0; bus.func_i = '0; bus.a_i = '0; bus.b_i = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.busy_o, bus.done_o, bus.dbz_o, bus.illegal_o} !== 4'b0 ||
          bus.result_o !== 32'd0) begin
         errors++;
         $display("FAIL reset: busy=%b done=%b dbz=%b ill=%b res=%h, want all 0",
                  bus.busy_o, bus.done_o, bus.dbz_o, bus.illegal_o, bus.result_o);
      end
      rst_n = 1'b1;
   endtask

   // Directed table: func, a, b, expected result, dbz, illegal, latency.
   task automatic test_table(input string name, input logic [3:0] f [],
                             input logic [31:0] a [], input logic [31:0] b [],
                             input logic [31:0] e [], input logic [1:0] fl [],
                             input int el []);
      logic [31:0] r; logic dz, il; int lat, bsy;
      for (int i = 0; i < f.size(); i++) begin
         do_op(f[i], a[i], b[i], r, dz, il, lat, bsy);
         checks += 3;
         if (r !== e[i]) begin
            errors++;
            $display("FAIL %s[%0d] result: got %h want %h", name, i, r, e[i]);
         end
         if ({dz, il} !== fl[i]) begin
            errors++;
            $display("FAIL %s[%0d] flags dbz/ill: got %b%b want %b",
                     name, i, dz, il, fl[i]);
         end
         if (lat != el[i] || bsy != el[i] - 1) begin
            errors++;
            $display("FAIL %s[%0d] timing: lat %0d busy %0d want lat %0d busy %0d",
                     name, i, lat, bsy, el[i], el[i] - 1);
         end
      end
   endtask

   task automatic test_unary();
      test_table("unary", '{4'd8, 4'd9, 4'd10, 4'd11},
                 '{32'h0000_8001, 32'h0000_007F, 32'h0, 32'h8000_0000},
                 '{32'h0, 32'h0, 32'h0, 32'h0},
                 '{32'hFFFF_8001, 32'h0000_007F, 32'hFFFF_FFFF, 32'h8000_0000},
                 '{2'b00, 2'b00, 2'b00, 2'b00}, '{1, 1, 1, 1});
   endtask

   task automatic test_multiply();
      test_table("mul", '{4'd6, 4'd0, 4'd7, 4'd3},
                 '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1234},
                 '{32'd7, 32'd7, 32'd2, 32'd5678},
                 '{32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'h0000_0001, 32'd7006652},
                 '{2'b00, 2'b00, 2'b00, 2'b00}, '{34, 34, 34, 34});
   endtask

   task automatic test_divide();
      test_table("div", '{4'd1, 4'd2, 4'd1, 4'd4, 4'd5},
                 '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'd100},
                 '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'd7, 32'd7},
                 '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd14, 32'd2},
                 '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00}, '{34, 34, 34, 34, 34});
   endtask

   task automatic test_boundaries();
      test_table("bound", '{4'd1, 4'd2, 4'd13, 4'd4},
                 '{32'd5, 32'd5, 32'd77, 32'd9},
                 '{32'd0, 32'd0, 32'd3, 32'd3},
                 '{32'hFFFF_FFFF, 32'd5, 32'd0, 32'd3},
                 '{2'b10, 2'b10, 2'b01, 2'b00}, '{1, 1, 1, 34});
   endtask

   task automatic test_reset_mid();
      logic [31:0] r; logic dz, il; int lat, bsy, seen;
      @(negedge clk);
      bus.start_i = 1'b1; bus.func_i = 4'd3;
      bus.a_i = 32'd1000; bus.b_i = 32'd1000;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.result_o !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid: busy=%b done=%b res=%h, want 0/0/0",
                  bus.busy_o, bus.done_o, bus.result_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done_o) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL reset_mid spurious done: got %0d pulses want 0", seen);
      end
      do_op(4'd11, 32'd1, 32'd0, r, dz, il, lat, bsy);
      checks++;
      if (r !== 32'hFFFF_FFFF || lat != 1) begin
         errors++;
         $display("FAIL reset_mid neg: res %h lat %0d want FFFFFFFF lat 1", r, lat);
      end
   endtask

   task automatic test_ignore_busy();
      int lat;
      @(negedge clk);
      bus.start_i = 1'b1; bus.func_i = 4'd4; bus.a_i = 32'd100; bus.b_i = 32'd7;
      @(negedge clk);
      bus.start_i = 1'b0;
      lat = 1;
      while (!bus.done_o && lat < 100) begin
         if (lat == 5) begin
            bus.start_i = 1'b1; bus.func_i = 4'd10; bus.a_i = 32'd5;
         end else begin
            bus.start_i = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      bus.start_i = 1'b0;
      checks++;
      if (bus.result_o !== 32'd14 || lat != 34) begin
         errors++;
         $display("FAIL ignore_busy: res %h lat %0d want 0000000e lat 34",
                  bus.result_o, lat);
      end
      @(negedge clk);
      checks++;
      if (bus.done_o !== 1'b0 || bus.result_o !== 32'd14) begin
         errors++;
         $display("FAIL ignore_busy after: done %b res %h want 0 0000000e",
                  bus.done_o, bus.result_o);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      @(negedge clk);
      bus.start_i = 1'b1; bus.func_i = 4'd3; bus.a_i = 32'd6; bus.b_i = 32'd7;
      @(negedge clk);
      bus.func_i = 4'd10; bus.a_i = 32'd0; bus.b_i = 32'd0;
      lat = 1;
      while (!bus.done_o && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (bus.result_o !== 32'd42 || lat != 34) begin
         errors++;
         $display("FAIL b2b first: res %h lat %0d want 0000002a lat 34",
                  bus.result_o, lat);
      end
      @(negedge clk);
      bus.start_i = 1'b0;
      checks++;
      if (bus.done_o !== 1'b1 || bus.result_o !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL b2b second: done %b res %h want 1 ffffffff",
                  bus.done_o, bus.result_o);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, r, er; logic [3:0] f;
      logic dz, il, edz, eil; int lat, bsy, elat, ebsy;
      for (int i = 0; i < 40; i++) begin
         f = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 5))
            0: a = 32'h8000_0000;
            1: a = 32'hFFFF_FFFF;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = $urandom_range(1, 300);
            default: b = $urandom;
         endcase
         model(f, a, b, er, edz, eil, elat, ebsy);
         do_op(f, a, b, r, dz, il, lat, bsy);
         checks += 3;
         if (r !== er) begin
            errors++;
            $display("FAIL rand[%0d] f=%0d a=%h b=%h result: got %h want %h",
                     i, f, a, b, r, er);
         end
         if ({dz, il} !== {edz, eil}) begin
            errors++;
            $display("FAIL rand[%0d] f=%0d flags: got %b%b want %b%b",
                     i, f, dz, il, edz, eil);
         end
         if (lat != elat || bsy != ebsy) begin
            errors++;
            $display("FAIL rand[%0d] f=%0d timing: lat %0d busy %0d want %0d %0d",
                     i, f, lat, bsy, elat, ebsy);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_unary();
      test_multiply();
      test_divide();
      test_boundaries();
      test_reset_mid();
      test_ignore_busy();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bexkat2_intseq.md
Name: bexkat2_intseq

Overview:
Multi-cycle sequencer and datapath for the bexkat2 integer unit (T_INT/T_INTU opcodes). It accepts one operation at a time from the control FSM (S_INT/S_INT2/S_INT3), using the intfunc_t encoding. Single-cycle functions complete in one cycle. Multiply and divide are run iteratively, one bit per cycle, so that no wide combinational multiplier or divider is needed. The result is handed back to the MDR_INT path with a done pulse.

Parameters:
WIDTH, 32, operand/result width in bits (must be >=16, even)

Ports:
clk_i  in  1  system clock, all state on rising edge
rst_i  in  1  asynchronous, active-low reset
start_i  in  1  request; accepted only when busy_o=0
func_i  in  4  intfunc_t: MUL=0 DIV=1 MOD=2 MULU=3 DIVU=4 MODU=5 MULX=6 MULUX=7 EXT=8 EXTB=9 COM=10 NEG=11
a_i  in  WIDTH  operand A (dividend / multiplicand / unary source)
b_i  in  WIDTH  operand B (divisor / multiplier)
busy_o  out  1  operation in progress
done_o  out  1  one-cycle completion pulse
result_o  out  WIDTH  result, valid with done_o, held until next done_o
dbz_o  out  1  divide-by-zero flag, valid with done_o, held
illegal_o  out  1  func_i 12..15 flag, valid with done_o, held

Behaviour:
- Reset (rst_i=0, any time, including mid-operation): state=IDLE, busy_o=0, done_o=0, result_o=0, dbz_o=0, illegal_o=0. Any in-flight operation is discarded with no done_o.
- States:
  - IDLE: start_i=1 latches a_i, b_i and func_i.
  - RUN: iterative step; an internal counter runs WIDTH-1 down to 0.
  - FIX: sign correction and result selection; always goes to IDLE.
- Acceptance and single-cycle path:
  - start_i while busy_o=1 is ignored; no queueing.
  - EXT, EXTB, COM, NEG, illegal codes and divide-by-zero never leave IDLE. done_o and result are registered on the accepting edge, so latency is 1 cycle.
- Iterative path:
  - IDLE->RUN on accept. RUN lasts WIDTH cycles, then FIX for 1 cycle, then IDLE.
  - done_o is asserted in the first IDLE cycle, exactly WIDTH+2 cycles after the accept cycle.
  - busy_o=1 in RUN and FIX only.
  - start_i may be asserted in the same cycle as done_o and is accepted.
- Unary functions:
  - EXT = sign-extend a[15:0].
  - EXTB = sign-extend a[7:0].
  - COM = ~a.
  - NEG = two's complement of a. NEG of 0x80000000 gives 0x80000000, with no flag.
- Multiply:
  - Signed variants take |a| and |b|; unsigned variants take the raw values.
  - Radix-2 shift-add into a 2*WIDTH accumulator.
  - FIX negates the 2*WIDTH product when the variant is signed and sign(a)!=sign(b).
  - MUL/MULU return the low WIDTH bits; MULX/MULUX return the high WIDTH bits.
- Divide:
  - Restoring division on magnitudes (signed) or raw values (unsigned); the quotient is built MSB first.
  - Signed: the quotient is negated if sign(a)!=sign(b), and the remainder takes the sign of a (truncation toward zero).
  - DIV/DIVU return the quotient; MOD/MODU return the remainder.
  - Signed overflow 0x80000000 / -1 gives quotient 0x80000000 and remainder 0, with no flag.
- Divide by zero (b=0, any of DIV/MOD/DIVU/MODU):
  - Completes in 1 cycle with dbz_o=1.
  - Quotient result = all ones; remainder result = a.
- Illegal func 12..15: 1-cycle completion, result 0, illegal_o=1.
- dbz_o and illegal_o are cleared on every other completion.
- Operands are not sampled after accept, so changes on a_i/b_i/func_i during busy have no effect.

Test Plan:
- Reset mid-operation: assert MULU, pull rst_i low in RUN cycle 5, release -> busy_o=0, result_o=0, no done_o; next NEG a=1 -> done_o after 1 cycle, result 0xFFFFFFFF.
- Unary ops: EXT a=0x00008001 -> 0xFFFF8001; EXTB a=0x0000007F -> 0x0000007F; COM a=0 -> 0xFFFFFFFF; each with done_o exactly 1 cycle after start and busy_o never high.
- Multiply pair:
  - MULX a=-3, b=7 -> result 0xFFFFFFFF, and MUL with the same operands -> 0xFFFFFFEB.
  - MULUX a=0xFFFFFFFF, b=2 -> 0x00000001.
  - All complete with done_o 34 cycles after start and busy_o high for 33 cycles.
- Signed divide:
  - DIV a=-7, b=2 -> 0xFFFFFFFD.
  - MOD a=-7, b=2 -> 0xFFFFFFFF.
  - DIV a=0x80000000, b=-1 -> 0x80000000.
  - DIVU a=100, b=7 -> 14; MODU a=100, b=7 -> 2.
- Boundaries:
  - DIV a=5, b=0 -> 1-cycle done, result 0xFFFFFFFF, dbz_o=1.
  - MOD a=5, b=0 -> result 5, dbz_o=1.
  - func=13 -> result 0, illegal_o=1.
  - A following DIVU 9/3 -> result 3 with both flags cleared.
- Handshake:
  - start_i pulsed during RUN with different operands -> ignored, first result unchanged.
  - start_i held high through done_o cycle -> second op accepted on the done cycle (back-to-back).
